bcd_serial_sub: RTL and testbench
=================================

BCD_SERIAL_SUB -- requirements
Module: bcd_serial_sub

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 SHALL have port a, input, 4*DIGITS bits: minuend as packed BCD; digit 0 is at [3:0].
REQ-006 SHALL have port b, input, 4*DIGITS bits: subtrahend as packed BCD, same packing as a.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking that results are valid.
REQ-009 SHALL have port diff, output, 4*DIGITS bits: packed BCD result.
REQ-010 SHALL have port neg, output, 1 bit: high when A < B.
REQ-011 SHALL have port invalid, output, 1 bit: high when an operand digit was greater than 9.

Function
REQ-012 SHALL compute A - B as A + C9(B) + 1, digit-serial, least significant digit first, one digit per clock.
- C9(d) is the BCD 9's complement, 9 - d.
REQ-013 SHALL use an FSM with states IDLE, RUN, FIX, DONE; FIX exists only under REQ-027.
REQ-014 SHALL, in IDLE, accept start=1 at rising edge k: latch a and b, set carry=1, set digit index=0, enter RUN, and raise busy.
REQ-015 SHALL ignore start while in RUN, FIX or DONE.
- A start that overlaps done is not queued.
REQ-016 SHALL, in each RUN cycle for digit i: form s = a_i + (9 - b_i) + carry (5 bits).
- If s > 9: digit = (s + 6)[3:0] and carry = 1.
- Otherwise: digit = s[3:0] and carry = 0.
REQ-017 SHALL, after digit DIGITS-1, set neg = ~carry_out.
REQ-018 SHALL enter DONE at edge k+DIGITS when FIX is not taken; done=1 and busy=0 for exactly one cycle, then IDLE.
REQ-019 SHALL hold diff, neg and invalid stable from the DONE cycle until the next accepted start.
- Their values during RUN and FIX are unspecified.
REQ-020 SHALL, if any latched digit of a or b exceeds 9: set invalid=1 in DONE, force diff to all zeros and neg to 0, and keep the same latency.
REQ-021 SHALL report 0 - 0 as diff=0, neg=0; a negative zero never occurs.
REQ-022 SHALL, without REQ-027, leave diff as the raw 10's complement result when neg=1 (e.g. 0127-0532 gives 9595).

Reset
REQ-023 SHALL, on rst=1 and regardless of clk, force state=IDLE, busy=0, done=0, diff=0, neg=0, invalid=0, carry=0, index=0.
REQ-024 SHALL, on reset during RUN or FIX, abandon the operation; no done pulse is ever produced for it.
REQ-025 SHALL, on rst deassertion, accept start at the first rising edge at which rst is low.

Configuration
REQ-026 SHALL provide the macro BCD_SUB_SIGN_MAG_EN, which selects the negative-result format.
REQ-027 SHALL, with BCD_SUB_SIGN_MAG_EN defined, enter FIX instead of DONE when neg=1.
- FIX recomplements diff serially as C9(diff) + 1 using the REQ-016 digit rule, one digit per cycle.
- diff becomes the magnitude |A-B|, with neg=1.
- done occurs at edge k+2*DIGITS.
- When neg=0, FIX is skipped and timing follows REQ-018.
REQ-028 SHALL, without BCD_SUB_SIGN_MAG_EN, contain no FIX state or logic; negative results follow REQ-022.

Verification
REQ-029 SHALL cover a positive result: DIGITS=4, a=0532, b=0127, start at edge k -> done at k+4, diff=0405, neg=0, invalid=0.
REQ-030 SHALL cover a negative result: a=0127, b=0532.
- Without macro -> done at k+4, diff=9595, neg=1.
- With macro -> done at k+8, diff=0405, neg=1.
REQ-031 SHALL cover boundaries:
- a=9999, b=0000 -> diff=9999, neg=0.
- a=0000, b=0000 -> diff=0000, neg=0.
- a=0000, b=0001 without macro -> diff=9999, neg=1.
REQ-032 SHALL cover an invalid digit: a=00A0 (a digit of 10), b=0001 -> done at k+4, invalid=1, diff=0000, neg=0.
REQ-033 SHALL cover reset mid-operation: rst pulsed at edge k+2 -> busy=0 immediately, no done pulse; a new start at the next edge returns a correct result.
REQ-034 SHALL cover ignored starts: start held high through the whole operation -> exactly one done per accepted operation, and the next acceptance occurs in IDLE after DONE.

Source files
------------

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor: A - B = A + C9(B) + 1, one digit per clock, LSD first.
// Define BCD_SUB_SIGN_MAG_EN to recomplement negative results into sign-magnitude form.
module bcd_serial_sub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

`ifdef BCD_SUB_SIGN_MAG_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic           carry_q, carry_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           neg_q, neg_d, inv_q, inv_d;

  logic [DIGITS-1:0] bad_a, bad_b;
  logic [3:0]        op_x, op_y, digit_res;
  logic [4:0]        sum, sum_adj;
  logic              carry_out;
  logic [W-1:0]      diff_shift;

  // Operand validity is judged on the values latched at start.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
    assign bad_a[gi] = (a[4*gi +: 4] > 4'd9);
    assign bad_b[gi] = (b[4*gi +: 4] > 4'd9);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      neg_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      neg_q   <= neg_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    neg_d   = neg_q;
    inv_d   = inv_q;
    op_x    = a_q[3:0];
    op_y    = b_q[3:0];
`ifdef BCD_SUB_SIGN_MAG_EN
    // Recomplement pass: 0 + C9(diff digit) + carry reuses the same digit adder.
    if (state_q == FIX) begin
      op_x = 4'd0;
      op_y = diff_q[3:0];
    end
`endif
    sum        = {1'b0, op_x} + (5'd9 - {1'b0, op_y}) + {4'd0, carry_q};
    sum_adj    = sum + 5'd6;
    carry_out  = (sum > 5'd9);
    digit_res  = carry_out ? sum_adj[3:0] : sum[3:0];
    diff_shift = (diff_q >> 4) | (W'(digit_res) << (W - 4));

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          inv_d   = |{bad_a, bad_b};
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        diff_d  = diff_shift;
        carry_d = carry_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          neg_d   = ~carry_out;
          state_d = DONE;
          if (inv_q) begin
            diff_d = '0;
            neg_d  = 1'b0;
          end
`ifdef BCD_SUB_SIGN_MAG_EN
          else if (!carry_out) begin
            carry_d = 1'b1;
            state_d = FIX;
          end
`endif
        end
      end
`ifdef BCD_SUB_SIGN_MAG_EN
      FIX: begin
        diff_d  = diff_shift;
        carry_d = carry_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BCD_SUB_SIGN_MAG_EN
  assign busy = (state_q == RUN) || (state_q == FIX);
`else
  assign busy = (state_q == RUN);
`endif
  assign done    = (state_q == DONE);
  assign diff    = diff_q;
  assign neg     = neg_q;
  assign invalid = inv_q;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Self-checking bench for bcd_serial_sub: directed corner cases, random operands vs an
// integer-arithmetic reference, mid-operation reset and start held high.
module tb_bcd_serial_sub;

  localparam int D = 4;
  localparam int W = 4 * D;
`ifdef BCD_SUB_SIGN_MAG_EN
  localparam bit SM = 1'b1;
`else
  localparam bit SM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, neg, invalid;
  logic [W-1:0] diff;

  int pass_cnt = 0;
  int total_cnt = 0;

  bcd_serial_sub #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .neg(neg), .invalid(invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain decimal arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] ed, output logic en,
                                output logic ei, output int elat);
    longint ai = 0, bi = 0, r, pw = 1;
    bit bad = 0;
    for (int i = 0; i < D; i++) begin
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1;
      ai += longint'(av[4*i +: 4]) * pw;
      bi += longint'(bv[4*i +: 4]) * pw;
      pw *= 10;
    end
    elat = D;
    ed = '0;
    if (bad) begin
      en = 1'b0;
      ei = 1'b1;
    end else begin
      ei = 1'b0;
      en = (ai < bi);
      r = ai - bi;
      if (r < 0) begin
        if (SM) begin
          r = -r;
          elat = 2 * D;
        end else begin
          r = r + pw;
        end
      end
      for (int i = 0; i < D; i++) begin
        ed[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
  endfunction

  function automatic logic [3:0] rand_digit(input int bad_pct);
    if ($urandom_range(0, 99) < bad_pct) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  // Waits for IDLE, launches one subtraction and returns what the DUT reported.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat,
                       output logic [W-1:0] od, output logic on, output logic oi,
                       output logic ob);
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    ob = busy;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = -1;
    for (int c = 1; c <= 3 * D + 4; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    od = diff;
    on = neg;
    oi = invalid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (diff !== '0) $display("FAIL reset_diff: got %h want 0", diff); else pass_cnt++;
    total_cnt++; if (neg !== 1'b0) $display("FAIL reset_neg: got %b want 0", neg); else pass_cnt++;
    total_cnt++; if (invalid !== 1'b0) $display("FAIL reset_invalid: got %b want 0", invalid); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("reset: busy=%b done=%b diff=%h neg=%b invalid=%b", busy, done, diff, neg, invalid);
  endtask

  logic [W-1:0] ta [6] = '{16'h0532, 16'h0127, 16'h9999, 16'h0000, 16'h0000, 16'h00A0};
  logic [W-1:0] tb [6] = '{16'h0127, 16'h0532, 16'h0000, 16'h0000, 16'h0001, 16'h0001};
  logic [W-1:0] td [6] = '{16'h0405, SM ? 16'h0405 : 16'h9595, 16'h9999, 16'h0000,
                           SM ? 16'h0001 : 16'h9999, 16'h0000};
  logic         tn [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic         ti [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int           tl [6] = '{D, SM ? 2*D : D, D, D, SM ? 2*D : D, D};

  task automatic test_directed();
    int lat;
    logic [W-1:0] od;
    logic on, oi, ob;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], lat, od, on, oi, ob);
      $display("directed %0d: a=%h b=%h -> diff=%h neg=%b inv=%b lat=%0d", i, ta[i], tb[i], od, on, oi, lat);
      total_cnt++; if (ob !== 1'b1) $display("FAIL dir%0d_busy: got %b want 1", i, ob); else pass_cnt++;
      total_cnt++; if (lat != tl[i]) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); else pass_cnt++;
      total_cnt++; if (od !== td[i]) $display("FAIL dir%0d_diff: got %h want %h", i, od, td[i]); else pass_cnt++;
      total_cnt++; if (on !== tn[i]) $display("FAIL dir%0d_neg: got %b want %b", i, on, tn[i]); else pass_cnt++;
      total_cnt++; if (oi !== ti[i]) $display("FAIL dir%0d_invalid: got %b want %b", i, oi, ti[i]); else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++; if (done !== 1'b0) $display("FAIL dir%0d_done_width: got %b want 0", i, done); else pass_cnt++;
      total_cnt++; if (diff !== td[i]) $display("FAIL dir%0d_diff_hold: got %h want %h", i, diff, td[i]); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [W-1:0] av, bv, od, ed;
    logic on, oi, ob, en, ei;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < D; i++) begin
        av[4*i +: 4] = rand_digit(3);
        bv[4*i +: 4] = rand_digit(3);
      end
      if (n % 10 == 7) bv = av;
      model(av, bv, ed, en, ei, elat);
      do_op(av, bv, lat, od, on, oi, ob);
      $display("random %0d: a=%h b=%h -> diff=%h neg=%b inv=%b lat=%0d", n, av, bv, od, on, oi, lat);
      total_cnt++;
      if (lat != elat || od !== ed || on !== en || oi !== ei)
        $display("FAIL rand%0d: got diff=%h neg=%b inv=%b lat=%0d want diff=%h neg=%b inv=%b lat=%0d",
                 n, od, on, oi, lat, ed, en, ei, elat);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int lat = -1;
    logic [W-1:0] ed;
    logic en, ei;
    int elat;
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = 16'h0532;
    b = 16'h0127;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    a = 16'h0127;
    b = 16'h0532;
    start = 1'b1;
    model(a, b, ed, en, ei, elat);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 3 * D + 4; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    $display("reset_mid restart: diff=%h neg=%b inv=%b lat=%0d", diff, neg, invalid, lat);
    total_cnt++; if (lat != elat) $display("FAIL rstmid_latency: got %0d want %0d", lat, elat); else pass_cnt++;
    total_cnt++;
    if (diff !== ed || neg !== en || invalid !== ei)
      $display("FAIL rstmid_result: got diff=%h neg=%b inv=%b want diff=%h neg=%b inv=%b", diff, neg, invalid, ed, en, ei);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cnt = 0, prev = -1, first = -1;
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = 16'h0532;
    b = 16'h0127;
    start = 1'b1;
    for (int c = 1; c <= 4 * (D + 2); c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cnt++;
        $display("back_to_back: done at edge %0d diff=%h neg=%b", c, diff, neg);
        if (first < 0) first = c;
        total_cnt++; if (diff !== 16'h0405) $display("FAIL b2b_diff: got %h want 0405", diff); else pass_cnt++;
        if (prev >= 0) begin
          total_cnt++; if (c - prev != D + 2) $display("FAIL b2b_gap: got %0d want %0d", c - prev, D + 2); else pass_cnt++;
        end
        prev = c;
      end
    end
    @(negedge clk);
    start = 1'b0;
    total_cnt++; if (first != D + 1) $display("FAIL b2b_first: got %0d want %0d", first, D + 1); else pass_cnt++;
    total_cnt++; if (cnt != 4) $display("FAIL b2b_count: got %0d want 4", cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
